// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Contents: FSM state encoding, data width, idle line level, and a
// frame-length helper (cycles per byte when frames run back to back).
package uart_pkg;

    typedef enum logic [2:0] {
        REPOSO,
        LEER,
        CAPTURA,
        INICIO,
        DATOS,
        PARIDAD,
        PARADA
    } estado_t;

    localparam int   DATA_W  = 8;
    localparam logic TX_IDLE = 1'b1;

    // Cycles between consecutive rd_en pulses when the FIFO never runs dry.
    function automatic int trama_ciclos(input int clk_div, input int parity_en, input int stop_bits);
        return 3 + (1 + DATA_W + parity_en + stop_bits) * clk_div;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the byte FIFO and its consumer.
//   vacio     : FIFO empty flag (FIFO -> consumer)
//   fifo_dato : FIFO data_out, valid the cycle after an rd_en cycle
//   rd_en     : one-cycle read strobe (consumer -> FIFO)
// master = the consumer that issues rd_en; slave = the FIFO.
interface fifo_uart_tx_if;
    import uart_pkg::*;

    logic              vacio;
    logic [DATA_W-1:0] fifo_dato;
    logic              rd_en;

    modport master (input vacio, input fifo_dato, output rd_en);
    modport slave  (output vacio, output fifo_dato, input rd_en);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter for the UART transmitter.
//   clk   : system clock
//   rst   : synchronous active-low reset
//   clear : hold counter at zero (used outside of an active frame)
//   tick  : high on the last cycle of each bit period (count == CLK_DIV-1)
module uart_baud_gen #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned  W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] ULTIMO = W'(CLK_DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == ULTIMO) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == ULTIMO);

endmodule

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains the byte FIFO: start bit, 8 data bits
// LSB first, optional even parity, 1 or 2 stop bits.
//   clk             : system clock, rising edge
//   rst             : synchronous active-low reset
//   habilitar       : permits starting a new frame
//   fifo            : FIFO read handshake (vacio, fifo_dato, rd_en)
//   tx              : registered serial line, idle high
//   ocupado         : registered, high whenever the FSM is not in REPOSO
//   tramas_enviadas : completed-frame counter, wraps at 16 bits
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 16,
    parameter int unsigned PARITY_EN = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  habilitar,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  ocupado,
    output logic [15:0]           tramas_enviadas
);

    localparam logic [2:0] ULT_DATO   = 3'(DATA_W - 1);
    localparam logic [2:0] ULT_PARADA = 3'(STOP_BITS - 1);

    estado_t           r_estado, w_estado_sig;
    logic [DATA_W-1:0] r_shift;
    logic              r_paridad;
    logic [2:0]        r_bit;
    logic              r_tx, r_rd_en, r_ocupado;
    logic [15:0]       r_tramas;

    logic w_tick, w_clear, w_tx, w_bit_inc, w_bit_clr, w_fin_trama;

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_estado_sig = r_estado;
        w_tx         = TX_IDLE;
        w_clear      = 1'b0;
        w_bit_inc    = 1'b0;
        w_bit_clr    = 1'b0;
        w_fin_trama  = 1'b0;
        case (r_estado)
            REPOSO: begin
                w_clear = 1'b1;
                if (habilitar && !fifo.vacio) w_estado_sig = LEER;
            end
            LEER: begin
                w_clear      = 1'b1;
                w_estado_sig = CAPTURA;
            end
            CAPTURA: begin
                // Counter is zero on the first INICIO cycle so every bit lasts CLK_DIV cycles.
                w_clear      = 1'b1;
                w_bit_clr    = 1'b1;
                w_estado_sig = INICIO;
            end
            INICIO: begin
                w_tx = 1'b0;
                if (w_tick) w_estado_sig = DATOS;
            end
            DATOS: begin
                w_tx = r_shift[0];
                if (w_tick) begin
                    if (r_bit == ULT_DATO) begin
                        w_bit_clr    = 1'b1;
                        w_estado_sig = (PARITY_EN != 0) ? PARIDAD : PARADA;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            PARIDAD: begin
                w_tx = r_paridad;
                if (w_tick) w_estado_sig = PARADA;
            end
            PARADA: begin
                // r_bit is reused to count stop bits.
                if (w_tick) begin
                    if (r_bit == ULT_PARADA) begin
                        w_bit_clr    = 1'b1;
                        w_fin_trama  = 1'b1;
                        w_estado_sig = REPOSO;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            default: w_estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_estado  <= REPOSO;
            r_tx      <= TX_IDLE;
            r_rd_en   <= 1'b0;
            r_ocupado <= 1'b0;
            r_tramas  <= '0;
            r_shift   <= '0;
            r_paridad <= 1'b0;
            r_bit     <= '0;
        end else begin
            r_estado  <= w_estado_sig;
            // tx lags the state by one cycle; rd_en/ocupado are registered from
            // the next state so they line up with the state they describe.
            r_tx      <= w_tx;
            r_rd_en   <= (w_estado_sig == LEER);
            r_ocupado <= (w_estado_sig != REPOSO);
            if (w_fin_trama) r_tramas <= r_tramas + 16'd1;
            if (r_estado == CAPTURA) begin
                r_shift   <= fifo.fifo_dato;
                r_paridad <= ^fifo.fifo_dato;
            end else if (r_estado == DATOS && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bit_clr)      r_bit <= '0;
            else if (w_bit_inc) r_bit <= r_bit + 3'd1;
        end
    end

    assign tx              = r_tx;
    assign ocupado         = r_ocupado;
    assign tramas_enviadas = r_tramas;
    assign fifo.rd_en      = r_rd_en;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Serial transmit stage directly downstream of the byte FIFO (fifo_if, 8-bit).
- Pops bytes from the FIFO using its rd_en/vacio handshake.
- Sends each byte as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
- Acts as the FIFO's read-side consumer and the design's serial output towards the board pin.

Parameters:
CLK_DIV, 16, clk cycles per serial bit; legal range 2..65535.
PARITY_EN, 0, 1 = append even-parity bit after data bits.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, synchronous, active-low.
habilitar  input  1  1 = allowed to start new frames.
vacio  input  1  FIFO empty flag.
fifo_dato  input  8  FIFO data_out; valid the cycle after a rd_en cycle.
rd_en  output  1  FIFO read strobe; registered, one-cycle pulse per byte.
tx  output  1  serial line; idle high; registered.
ocupado  output  1  1 whenever state != REPOSO; registered.
tramas_enviadas  output  16  count of completed frames; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=REPOSO; tx=1, rd_en=0, ocupado=0, tramas_enviadas=0.
  - Baud counter, bit counter and shift register cleared.
  - Mid-frame reset aborts the frame; tx=1 from the next edge; the popped byte is lost, not re-read.
- FIFO contract: FIFO data_out is registered; a byte popped with rd_en in cycle N is valid on fifo_dato in cycle N+1.
- FSM states:
  - REPOSO
    - if habilitar=1 and vacio=0 -> LEER; else stay.
    - vacio is sampled only here.
  - LEER: rd_en=1 for exactly this cycle; -> CAPTURA.
  - CAPTURA
    - shift register <= fifo_dato; parity <= XOR of fifo_dato.
    - baud counter <= 0; -> INICIO.
  - INICIO: tx=0 for CLK_DIV cycles; -> DATOS.
  - DATOS
    - tx = shift[0]; shift right every CLK_DIV cycles.
    - bit counter 0..7; after bit 7 -> PARIDAD if PARITY_EN, else PARADA.
  - PARIDAD: tx = even-parity bit for CLK_DIV cycles; -> PARADA.
  - PARADA
    - tx=1 for STOP_BITS*CLK_DIV cycles.
    - On exit: tramas_enviadas+1; -> REPOSO.
- Bit timing:
  - Baud counter counts 0..CLK_DIV-1; a bit boundary occurs when the counter hits CLK_DIV-1.
  - Counter width = $clog2(CLK_DIV).
- tx timing: tx is registered, so each line level appears one cycle after the state/bit change and lasts exactly CLK_DIV cycles per bit.
- Frame period, back-to-back: 3 + (1+8+PARITY_EN+STOP_BITS)*CLK_DIV cycles per byte (REPOSO+LEER+CAPTURA overhead). Defaults: 163 cycles.
- habilitar:
  - Deasserting it mid-frame lets the current frame complete.
  - It only blocks the REPOSO->LEER transition.
- Empty handling:
  - rd_en is never asserted while vacio=1 was sampled in REPOSO.
  - If the FIFO empties during a frame, the block returns to REPOSO and idles with tx=1.
- Full handling: none. The FIFO lleno/casi_* flags are not consumed.
- tramas_enviadas counts only frames that reach the end of PARADA; aborted frames are not counted.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] estado_t {REPOSO, LEER, CAPTURA, INICIO, DATOS, PARIDAD, PARADA};
  - localparam DATA_W=8;
  - constant TX_IDLE=1'b1;
  - function trama_ciclos(CLK_DIV, PARITY_EN, STOP_BITS) for benches.
- Sub-module uart_baud_gen:
  - Inputs: clk, rst, clear.
  - Output: tick (1 when the counter hits CLK_DIV-1).
  - Parameter: CLK_DIV.

Test Plan:
- Reset: hold rst=0 for 3 cycles with vacio=0 -> tx=1, rd_en=0, ocupado=0, tramas_enviadas=0 throughout.
- Single byte 0xA5, defaults:
  - One rd_en pulse; tx low 16 cycles.
  - Then bits 1,0,1,0,0,1,0,1, each 16 cycles.
  - Then high ≥16 cycles; tramas_enviadas=1.
- Back-to-back, FIFO preloaded with 0x00,0xFF,0x3C:
  - Three rd_en pulses exactly 163 cycles apart.
  - tramas_enviadas=3; ocupado drops once vacio=1.
- PARITY_EN=1, STOP_BITS=2, CLK_DIV=4, byte 0x07:
  - Parity bit=1; tx high 8 cycles at end.
  - Frame 3+12*4=51 cycles.
- Corner: vacio=1, habilitar=1 for 200 cycles -> rd_en never 1. habilitar=0 from mid-DATOS -> frame completes, no further rd_en.
- Reset mid-DATOS of 0x55:
  - tx=1 the cycle after the reset edge; tramas_enviadas=0.
  - After reset release the next FIFO byte is sent intact.
